// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner.
// Contents:
//   btn_state_t        - per-channel debounce FSM state
//   COUNT_W            - width of the per-channel stable-sample counter
//   STABLE_SAMPLES_DEF - default number of equal samples needed to accept a change
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    localparam int unsigned COUNT_W            = 8;
    localparam int unsigned STABLE_SAMPLES_DEF = 4;

endpackage

// File: rtl/button_debounce_ch.sv
// Single button channel: 2-flop synchronizer, debounce FSM and stable-sample
// counter with registered level / pulse outputs.
// Optional feature macro: BUTTON_RELEASE_PULSE_EN adds release_pulse.
// Ports:
//   clk_in        in  system clock, rising edge
//   reset         in  asynchronous active-high reset
//   sample_en     in  one-cycle sample strobe
//   btn_raw       in  raw asynchronous button level, 1 = pressed
//   btn_level     out debounced level (1 in HELD / RELEASE_PEND)
//   press_pulse   out one-cycle pulse after an accepted press
//   release_pulse out one-cycle pulse after an accepted release (macro only)
module button_debounce_ch
    import button_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEF
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sample_en,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse
`ifdef BUTTON_RELEASE_PULSE_EN
    ,
    output logic release_pulse
`endif
);

    localparam logic [COUNT_W-1:0] LP_STABLE = COUNT_W'(STABLE_SAMPLES);
    localparam logic [COUNT_W-1:0] LP_ONE    = COUNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    btn_state_t         r_state;
    logic [COUNT_W-1:0] r_count;
    logic               r_level;
    logic               r_press;
`ifdef BUTTON_RELEASE_PULSE_EN
    logic               r_release;
`endif

    logic               w_synced;
    logic [COUNT_W-1:0] w_count_inc;
    logic               w_accept;

    // Synchronizer runs every clock, independent of the sample strobe.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_synced = r_sync2;

    // Saturating increment; acceptance is judged on the incremented value so the
    // sample that makes the run STABLE_SAMPLES long is the accepting one.
    assign w_count_inc = (r_count == '1) ? r_count : r_count + LP_ONE;
    assign w_accept    = (w_count_inc >= LP_STABLE);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state   <= RELEASED;
            r_count   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
`ifdef BUTTON_RELEASE_PULSE_EN
            r_release <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
`ifdef BUTTON_RELEASE_PULSE_EN
            r_release <= 1'b0;
`endif
            if (sample_en) begin
                case (r_state)
                    RELEASED: begin
                        if (w_synced) begin
                            r_state <= PRESS_PEND;
                            r_count <= LP_ONE;
                        end
                    end
                    PRESS_PEND: begin
                        if (w_synced) begin
                            if (w_accept) begin
                                r_state <= HELD;
                                r_count <= '0;
                                r_level <= 1'b1;
                                r_press <= 1'b1;
                            end else begin
                                r_count <= w_count_inc;
                            end
                        end else begin
                            r_state <= RELEASED;
                            r_count <= '0;
                        end
                    end
                    HELD: begin
                        if (!w_synced) begin
                            r_state <= RELEASE_PEND;
                            r_count <= LP_ONE;
                        end
                    end
                    RELEASE_PEND: begin
                        if (!w_synced) begin
                            if (w_accept) begin
                                r_state   <= RELEASED;
                                r_count   <= '0;
                                r_level   <= 1'b0;
`ifdef BUTTON_RELEASE_PULSE_EN
                                r_release <= 1'b1;
`endif
                            end else begin
                                r_count <= w_count_inc;
                            end
                        end else begin
                            r_state <= HELD;
                            r_count <= '0;
                        end
                    end
                    default: begin
                        r_state <= RELEASED;
                        r_count <= '0;
                        r_level <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign btn_level   = r_level;
    assign press_pulse = r_press;
`ifdef BUTTON_RELEASE_PULSE_EN
    assign release_pulse = r_release;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one independent debounce channel per
// button (synchronizer + FSM + counter in button_debounce_ch).
// Optional feature macro: BUTTON_RELEASE_PULSE_EN adds release_pulse.
// Ports:
//   clk_in        in  system clock, rising edge
//   reset         in  asynchronous active-high reset
//   sample_en     in  one-cycle sample strobe from the clock-enable divider
//   btn_raw       in  [NUM_BTN] raw button levels, 1 = pressed
//   btn_level     out [NUM_BTN] debounced levels
//   press_pulse   out [NUM_BTN] one-cycle pulse per accepted press
//   release_pulse out [NUM_BTN] one-cycle pulse per accepted release (macro only)
// Parameters:
//   NUM_BTN        number of channels
//   STABLE_SAMPLES consecutive equal samples to accept a change (2..255)
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned NUM_BTN        = 2,
    parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEF
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               sample_en,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse
`ifdef BUTTON_RELEASE_PULSE_EN
    ,
    output logic [NUM_BTN-1:0] release_pulse
`endif
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        button_debounce_ch #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_ch (
            .clk_in       (clk_in),
            .reset        (reset),
            .sample_en    (sample_en),
            .btn_raw      (btn_raw[g]),
            .btn_level    (btn_level[g]),
            .press_pulse  (press_pulse[g])
`ifdef BUTTON_RELEASE_PULSE_EN
            ,
            .release_pulse(release_pulse[g])
`endif
        );
    end

endmodule
